// File: rtl/ad9122_tx_feeder.sv
// ad9122_tx_feeder: buffers I/Q samples in a small FIFO, primes it, then
// streams one I/Q pair per clock to the AD9122 DDR transmit stage. Also
// sequences the DCI output-delay tap load (value, then a one-cycle pulse).
module ad9122_tx_feeder #(
  parameter int WIDTH       = 16,
  parameter int AW          = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] sample_q,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic [WIDTH-1:0] dac_a,
  output logic [WIDTH-1:0] dac_b,
  input  logic             set_delay_stb,
  input  logic [4:0]       set_delay_val,
  output logic [4:0]       delay_value,
  output logic             delay_reset,
  output logic             underrun,
  input  logic             underrun_clr,
  output logic [AW:0]      fifo_level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_L = (AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] dac_a_q, dac_a_d;
  logic [WIDTH-1:0] dac_b_q, dac_b_d;
  logic             underrun_q, underrun_d;
  logic [4:0]       delay_value_q, delay_value_d;
  logic             delay_pend_q, delay_pend_d;
  logic             delay_reset_q, delay_reset_d;

  logic [WIDTH-1:0] fifo_i_mem [DEPTH];
  logic [WIDTH-1:0] fifo_q_mem [DEPTH];

  logic full;
  logic empty;
  logic flush;
  logic push;
  logic pop_try;
  logic pop;
  logic underrun_evt;

  // FIFO handshake, flush on leaving a running state, and pop/underrun decode
  always_comb begin
    full         = (level_q == DEPTH_L);
    empty        = (level_q == '0);
    sample_ready = !full && rst_n;
    flush        = !run && (state_q != ST_IDLE);
    push         = sample_valid && sample_ready && !flush;
    pop_try      = (state_q == ST_STREAM) && run;
    pop          = pop_try && !empty;
    underrun_evt = pop_try && empty;
  end

  // Next-state, FIFO bookkeeping, output words, underrun flag and delay sequencer
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    dac_a_d       = '0;
    dac_b_d       = '0;
    underrun_d    = underrun_q;
    delay_value_d = delay_value_q;
    delay_pend_d  = 1'b0;
    delay_reset_d = 1'b0;

    if (!run) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_PRIME;
        ST_PRIME:  if (level_q >= PRIME_L) state_d = ST_STREAM;
        ST_STREAM: if (empty) state_d = ST_PRIME;
        default:   state_d = ST_IDLE;
      endcase
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end

    if (pop) begin
      dac_a_d = fifo_i_mem[rd_ptr_q];
      dac_b_d = fifo_q_mem[rd_ptr_q];
    end

    if (underrun_evt)      underrun_d = 1'b1;
    else if (underrun_clr) underrun_d = 1'b0;

    // A newer strobe restarts the sequence, so the pulse follows only the last one
    if (set_delay_stb) begin
      delay_value_d = set_delay_val;
      delay_pend_d  = 1'b1;
    end else begin
      delay_reset_d = delay_pend_q;
    end
  end

  // State and output registers; reset leaves a pending delay load so the
  // transmit stage is loaded with tap 0 right after reset release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      dac_a_q       <= '0;
      dac_b_q       <= '0;
      underrun_q    <= 1'b0;
      delay_value_q <= '0;
      delay_pend_q  <= 1'b1;
      delay_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      dac_a_q       <= dac_a_d;
      dac_b_q       <= dac_b_d;
      underrun_q    <= underrun_d;
      delay_value_q <= delay_value_d;
      delay_pend_q  <= delay_pend_d;
      delay_reset_q <= delay_reset_d;
    end
  end

  // FIFO storage write; contents need no reset since level/pointers guard them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_i_mem[wr_ptr_q] <= sample_i;
      fifo_q_mem[wr_ptr_q] <= sample_q;
    end
  end

  assign dac_a       = dac_a_q;
  assign dac_b       = dac_b_q;
  assign underrun    = underrun_q;
  assign delay_value = delay_value_q;
  assign delay_reset = delay_reset_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_ad9122_tx_feeder.sv
// Directed self-checking bench for ad9122_tx_feeder (WIDTH=16, AW=4, PRIME_LEVEL=8).
module tb_ad9122_tx_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] sample_i;
  logic [15:0] sample_q;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] dac_a;
  logic [15:0] dac_b;
  logic        set_delay_stb;
  logic [4:0]  set_delay_val;
  logic [4:0]  delay_value;
  logic        delay_reset;
  logic        underrun;
  logic        underrun_clr;
  logic [4:0]  fifo_level;

  int compared   = 0;
  int mismatched = 0;

  ad9122_tx_feeder #(.WIDTH(16), .AW(4), .PRIME_LEVEL(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .sample_i     (sample_i),
    .sample_q     (sample_q),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_a        (dac_a),
    .dac_b        (dac_b),
    .set_delay_stb(set_delay_stb),
    .set_delay_val(set_delay_val),
    .delay_value  (delay_value),
    .delay_reset  (delay_reset),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .fifo_level   (fifo_level)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the sample-side inputs
  task automatic applyStimulus(input logic runV, input logic validV,
                               input logic [15:0] iV, input logic [15:0] qV);
    run          = runV;
    sample_valid = validV;
    sample_i     = iV;
    sample_q     = qV;
  endtask

  // One comparison: counts it and reports a failure with observed/expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] wordI(input int n);
    return 16'hFFF0 + 16'(n * 3);
  endfunction

  function automatic logic [15:0] wordQ(input int n);
    return ~wordI(n);
  endfunction

  initial begin
    rst_n         = 1'b0;
    set_delay_stb = 1'b0;
    set_delay_val = 5'd0;
    underrun_clr  = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    #1;

    // Reset state
    repeat (3) step();
    checkOutput("rst_dac_a", dac_a, 0);
    checkOutput("rst_dac_b", dac_b, 0);
    checkOutput("rst_ready", sample_ready, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_delay_value", delay_value, 0);
    checkOutput("rst_delay_reset", delay_reset, 0);

    // Release: one delay load pulse with tap 0
    rst_n = 1'b1;
    step();
    checkOutput("init_pulse", delay_reset, 1);
    checkOutput("init_tap", delay_value, 0);
    checkOutput("init_ready", sample_ready, 1);
    step();
    checkOutput("init_pulse_end", delay_reset, 0);

    // Delay sequencer: single strobe, val 13
    set_delay_stb = 1'b1; set_delay_val = 5'd13;
    step();
    set_delay_stb = 1'b0;
    checkOutput("dly13_value", delay_value, 13);
    checkOutput("dly13_no_pulse_yet", delay_reset, 0);
    step();
    checkOutput("dly13_pulse", delay_reset, 1);
    checkOutput("dly13_value_hold", delay_value, 13);
    step();
    checkOutput("dly13_pulse_end", delay_reset, 0);

    // Back-to-back strobes: only one pulse, after the last, with val 9
    set_delay_stb = 1'b1; set_delay_val = 5'd5;
    step();
    checkOutput("dly5_value", delay_value, 5);
    set_delay_val = 5'd9;
    step();
    set_delay_stb = 1'b0;
    checkOutput("dly59_no_pulse_a", delay_reset, 0);
    checkOutput("dly9_value", delay_value, 9);
    step();
    checkOutput("dly59_pulse", delay_reset, 1);
    checkOutput("dly59_pulse_value", delay_value, 9);
    step();
    checkOutput("dly59_pulse_end", delay_reset, 0);

    // Prime with 8 words and stream them out, then underrun
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b1, 16'(k), 16'(16'h100 + k));
      step();
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
    checkOutput("prime_level8", fifo_level, 8);
    checkOutput("prime_dac_zero", dac_a, 0);
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("stream_dac_a", dac_a, k);
      checkOutput("stream_dac_b", dac_b, 16'h100 + k);
    end
    checkOutput("stream_no_underrun", underrun, 0);
    underrun_clr = 1'b1;
    step();
    checkOutput("underrun_dac_a", dac_a, 0);
    checkOutput("underrun_dac_b", dac_b, 0);
    checkOutput("underrun_set_beats_clr", underrun, 1);
    step();
    checkOutput("underrun_clr_alone", underrun, 0);
    underrun_clr = 1'b0;

    // Flush, then fill to full while idle
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    step();
    checkOutput("flush_level", fifo_level, 0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b1, 16'(16'h200 + k), 16'(16'h300 + k));
      step();
    end
    checkOutput("full_level", fifo_level, 16);
    checkOutput("full_ready", sample_ready, 0);
    applyStimulus(1'b0, 1'b1, 16'h2FF, 16'h3FF);
    step();
    checkOutput("full_17th_rejected", fifo_level, 16);
    checkOutput("full_idle_dac", dac_a, 0);

    // Run: first pop frees a slot and the held 17th word goes in
    run = 1'b1;
    step();
    step();
    step();
    checkOutput("resume_ready", sample_ready, 1);
    checkOutput("resume_level", fifo_level, 15);
    checkOutput("resume_first_word", dac_a, 16'h201);
    step();
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
    checkOutput("resume_push_pop_level", fifo_level, 15);
    checkOutput("resume_second_word", dac_a, 16'h202);
    for (int k = 3; k <= 16; k++) begin
      step();
      checkOutput("drain_dac_a", dac_a, 16'h200 + k);
      checkOutput("drain_dac_b", dac_b, 16'h300 + k);
    end
    step();
    checkOutput("drain_17th_a", dac_a, 16'h2FF);
    checkOutput("drain_17th_b", dac_b, 16'h3FF);

    // Continuous streaming with wrapping data and pointers
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    step();
    checkOutput("pre_cont_level", fifo_level, 0);
    for (int c = 0; c < 1010; c++) begin
      applyStimulus(1'b1, 1'b1, wordI(c), wordQ(c));
      step();
      if (c + 1 >= 10) begin
        checkOutput("cont_dac_a", dac_a, wordI(c - 9));
        checkOutput("cont_dac_b", dac_b, wordQ(c - 9));
      end
    end
    checkOutput("cont_no_underrun", underrun, 0);
    checkOutput("cont_ready", sample_ready, 1);
    checkOutput("cont_level", fifo_level, 9);

    // Drain to 5 queued, then drop run
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
    repeat (4) step();
    checkOutput("drop_level5", fifo_level, 5);
    checkOutput("drop_dac_before", dac_a, wordI(1004));
    run = 1'b0;
    step();
    checkOutput("drop_dac_a", dac_a, 0);
    checkOutput("drop_dac_b", dac_b, 0);
    checkOutput("drop_level", fifo_level, 0);

    // Restart: 7 words must not start streaming, the 8th does
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h500 + k), 16'(16'h600 + k));
      step();
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
    step();
    checkOutput("reprime_level7", fifo_level, 7);
    checkOutput("reprime_dac7a", dac_a, 0);
    step();
    checkOutput("reprime_dac7b", dac_a, 0);
    applyStimulus(1'b1, 1'b1, 16'h507, 16'h607);
    step();
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
    checkOutput("reprime_level8", fifo_level, 8);
    checkOutput("reprime_dac8a", dac_a, 0);
    step();
    checkOutput("reprime_dac8b", dac_a, 0);
    step();
    checkOutput("reprime_first_a", dac_a, 16'h500);
    checkOutput("reprime_first_b", dac_b, 16'h600);

    // Reset mid-stream
    rst_n = 1'b0;
    step();
    checkOutput("midrst_dac_a", dac_a, 0);
    checkOutput("midrst_level", fifo_level, 0);
    checkOutput("midrst_ready", sample_ready, 0);
    checkOutput("midrst_delay_value", delay_value, 0);
    checkOutput("midrst_delay_reset", delay_reset, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;
    step();
    checkOutput("midrst_init_pulse", delay_reset, 1);
    step();
    checkOutput("midrst_idle_dac", dac_a, 0);
    checkOutput("midrst_idle_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
